// File: rtl/bk_port_reg_if.sv
// rtl/bk_port_reg_if.sv - BK MPI bus control strobes and port select seen by bk_port_reg
interface bk_port_reg_if;
    logic nSYNCp;
    logic nDINp;
    logic nDOUTp;
    logic nWTBTp;
    logic nSELp;

    modport master (
        output nSYNCp,
        output nDINp,
        output nDOUTp,
        output nWTBTp,
        output nSELp
    );

    modport slave (
        input nSYNCp,
        input nDINp,
        input nDOUTp,
        input nWTBTp,
        input nSELp
    );
endinterface

// File: rtl/bk_port_reg.sv
// rtl/bk_port_reg.sv - BK parallel port register at 177714 (optional macro BK_PORT_READBACK_EN)
module bk_port_reg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLKp,
    input  logic          RSTp,
    bk_port_reg_if.slave  bus,
    inout  wire  [15:0]   nADp,
    inout  wire           nRPLYp,
    input  logic [15:0]   port_in,
    output logic [15:0]   port_out,
    output logic          wr_stb,
    output logic          bus_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WREPLY = 3'd2,
        READ   = 3'd3,
        RREPLY = 3'd4
    } state_t;

    // Raw bus inputs packed as {SEL, WTBT, DOUT, DIN, SYNC}
    logic [4:0]                    bus_raw;
    logic [SYNC_STAGES-1:0][4:0]   sync_q;
    logic [SYNC_STAGES-1:0]        fill_q;
    logic                          sync_valid;

    logic s_sync;
    logic s_din;
    logic s_dout;
    logic s_wtbt;
    logic s_sel;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        bus_err_d;
    logic        bus_err_q;
    logic        wr_stb_q;
    logic        rply_oe_q;
    logic        ad_oe_q;
    logic [15:0] port_out_q;
    logic [15:0] rd_q;
    logic [15:0] rd_data;

    assign bus_raw = {bus.nSELp, bus.nWTBTp, bus.nDOUTp, bus.nDINp, bus.nSYNCp};

    // Synchroniser chains reset to the idle (high) level; fill_q marks when the
    // chain output reflects real bus samples rather than the reset fill.
    always_ff @(posedge CLKp) begin
        if (RSTp) begin
            sync_q <= '1;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_raw};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_valid = fill_q[SYNC_STAGES-1];
    assign s_sync     = ~sync_q[SYNC_STAGES-1][0];
    assign s_din      = ~sync_q[SYNC_STAGES-1][1];
    assign s_dout     = ~sync_q[SYNC_STAGES-1][2];
    assign s_wtbt     = ~sync_q[SYNC_STAGES-1][3];
    assign s_sel      = ~sync_q[SYNC_STAGES-1][4];

`ifdef BK_PORT_READBACK_EN
    logic unused_port_in;
    assign unused_port_in = ^port_in;
    assign rd_data        = port_out_q;
`else
    assign rd_data        = port_in;
`endif

    // Next-state decode; armed_q blocks strobes left low across reset or an
    // aborted/illegal cycle until both have been seen released once.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        bus_err_d = 1'b0;

        if (sync_valid && !s_din && !s_dout) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && s_sel) begin
                    if (s_dout && !s_din) begin
                        state_d = WRITE;
                    end else if (s_din && !s_dout) begin
                        state_d = READ;
                    end else if (s_din && s_dout) begin
                        bus_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            WRITE:  state_d = WREPLY;
            WREPLY: if (!s_dout) state_d = IDLE;
            READ:   state_d = RREPLY;
            RREPLY: if (!s_din) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Losing SYNC mid-transfer aborts whatever is in progress.
        if ((state_q != IDLE) && !s_sync) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
            armed_d   = 1'b0;
        end
    end

    // State, port register, captured read data and registered bus drive enables.
    always_ff @(posedge CLKp) begin
        if (RSTp) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            port_out_q <= 16'h0000;
            rd_q       <= 16'h0000;
            wr_stb_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            rply_oe_q  <= 1'b0;
            ad_oe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            wr_stb_q  <= (state_d == WRITE);
            bus_err_q <= bus_err_d;
            rply_oe_q <= (state_d == WREPLY) || (state_d == RREPLY);
            ad_oe_q   <= (state_d == READ) || (state_d == RREPLY);
            if (state_d == WRITE) begin
                if (s_wtbt) begin
                    port_out_q <= {port_out_q[15:8], ~nADp[7:0]};
                end else begin
                    port_out_q <= ~nADp;
                end
            end
            if (state_d == READ) begin
                rd_q <= rd_data;
            end
        end
    end

    assign nADp     = ad_oe_q   ? ~rd_q : 16'bz;
    assign nRPLYp   = rply_oe_q ? 1'b0  : 1'bz;
    assign port_out = port_out_q;
    assign wr_stb   = wr_stb_q;
    assign bus_err  = bus_err_q;

endmodule
